// File: rtl/c_arb_grant_hold.sv
// c_arb_grant_hold: holds a matrix-arbiter grant for a whole packet, releasing on the winner's tail flit.
// Define C_ARB_GRANT_HOLD_TIMEOUT_EN to force a release after max_hold consecutive locked cycles.
module c_arb_grant_hold #(
    parameter int num_ports = 32,
    parameter int max_hold  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    input  logic [num_ports-1:0] req,
    input  logic [num_ports-1:0] tail,
    output logic [num_ports-1:0] arb_req,
    input  logic [num_ports-1:0] arb_gnt,
    output logic                 arb_update,
    output logic [num_ports-1:0] gnt,
    output logic                 locked,
    output logic                 timeout
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state_q, state_d;
    logic [num_ports-1:0] gnt_q, gnt_d;
    logic norm_rel, force_rel, rel, hold, accept;

    assign locked   = state_q == LOCKED;
    assign gnt      = gnt_q;
    assign norm_rel = locked & |(gnt_q & req & tail);
    assign rel      = norm_rel | force_rel;
    assign hold     = locked & ~rel;
    assign accept   = |arb_gnt & ~hold;
    assign timeout  = force_rel;

    // Reset is asynchronous, so the arbiter-facing combinational outputs are gated with it too.
    assign arb_req    = reset ? '0 : !locked ? req : rel ? req & ~gnt_q : '0;
    assign arb_update = accept & active & ~reset;

    always_comb begin
        state_d = accept | hold ? LOCKED : IDLE;
        gnt_d   = accept ? arb_gnt : hold ? gnt_q : '0;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
        end else if (active) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end

`ifdef C_ARB_GRANT_HOLD_TIMEOUT_EN
    localparam int cw = $clog2(max_hold);
    localparam logic [cw-1:0] cnt_max = cw'(max_hold - 1);
    logic [cw-1:0] cnt_q, cnt_d;

    assign force_rel = locked & (cnt_q == cnt_max) & ~norm_rel;

    always_comb
        cnt_d = hold ? cnt_q + cw'(cnt_q != cnt_max) : '0;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt_q <= '0;
        else if (active)
            cnt_q <= cnt_d;
`else
    assign force_rel = 1'b0;
`endif

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(arb_gnt));
    a_max_hold: assert property (@(posedge clk) disable iff (reset) max_hold >= 2 && max_hold <= 65536);
`endif
endmodule

// File: tb/tb_c_arb_grant_hold.sv
// tb_c_arb_grant_hold: directed and random checks of c_arb_grant_hold against a packet-level model.
module tb_c_arb_grant_hold;
    localparam int NP = 4;
    localparam int MH = 4;
`ifdef C_ARB_GRANT_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic active = 1'b1;
    logic [NP-1:0] req = '0, tail = '0, arb_gnt = '0;
    logic [NP-1:0] arb_req, gnt;
    logic arb_update, locked, timeout;

    int n_cmp = 0, n_err = 0;
    int holder = -1;
    int held = 0;
    int ptr = 0;

    c_arb_grant_hold #(.num_ports(NP), .max_hold(MH)) dut (
        .clk(clk), .reset(reset), .active(active), .req(req), .tail(tail),
        .arb_req(arb_req), .arb_gnt(arb_gnt), .arb_update(arb_update),
        .gnt(gnt), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Round-robin stand-in for the upstream arbiter: first requester at or after ptr.
    function automatic int pick(input logic [NP-1:0] r);
        for (int k = 0; k < NP; k++)
            if (r[(ptr + k) % NP]) return (ptr + k) % NP;
        return -1;
    endfunction

    // One cycle: drive inputs, compare against the model, then advance model and clock.
    task automatic step(input logic [NP-1:0] r, input logic [NP-1:0] t, input logic a);
        bit lk, nrel, frel, rel, acc;
        logic [NP-1:0] ereq;
        int w;
        lk   = holder >= 0;
        nrel = lk && r[holder] && t[holder];
        frel = TO_EN && lk && !nrel && held == MH - 1;
        rel  = nrel || frel;
        ereq = !lk ? r : rel ? r & ~(NP'(1) << holder) : '0;
        w    = pick(ereq);
        acc  = w >= 0 && (!lk || rel);
        req = r; tail = t; active = a;
        arb_gnt = w >= 0 ? NP'(1) << w : '0;
        #1;
        chk("arb_req", 32'(arb_req), 32'(ereq));
        chk("arb_update", 32'(arb_update), 32'(acc && a));
        chk("gnt", 32'(gnt), lk ? 32'(1) << holder : 32'd0);
        chk("locked", 32'(locked), 32'(lk));
        chk("timeout", 32'(timeout), 32'(frel));
        if (a) begin
            if (acc) begin
                holder = w; held = 0; ptr = (w + 1) % NP;
            end else if (!lk || rel) begin
                holder = -1; held = 0;
            end else if (held < MH - 1) begin
                held++;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        req = 4'hF;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_arb_req", 32'(arb_req), 0);
        chk("rst_arb_update", 32'(arb_update), 0);
        chk("rst_timeout", 32'(timeout), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        // 4-flit packet on port 0
        repeat (4) step(4'h1, 4'h0, 1'b1);
        step(4'h1, 4'h1, 1'b1);
        step(4'h0, 4'h0, 1'b1);
        // port 0 two flits, then port 1 single flit with no bubble
        step(4'h3, 4'h0, 1'b1);
        step(4'h3, 4'h1, 1'b1);
        step(4'h2, 4'h2, 1'b1);
        step(4'h0, 4'h0, 1'b1);
        // holder drops req without tail
        step(4'h1, 4'h0, 1'b1);
        step(4'h0, 4'h0, 1'b1);
        step(4'h6, 4'h0, 1'b1);
        step(4'h1, 4'h1, 1'b1);
        // single-flit packets on all ports
        repeat (8) step(4'hF, 4'hF, 1'b1);
        step(4'h0, 4'h0, 1'b1);
        // clock-gated cycles hold state
        step(4'h4, 4'h0, 1'b1);
        repeat (3) step(4'hC, 4'h4, 1'b0);
        // port 2 holds without tail while port 3 waits
        repeat (6) step(4'hC, 4'h0, 1'b1);
        // asynchronous reset mid-packet
        reset = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_locked", 32'(locked), 0);
        chk("arst_arb_req", 32'(arb_req), 0);
        chk("arst_arb_update", 32'(arb_update), 0);
        holder = -1; held = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        step(4'h8, 4'h0, 1'b1);
        step(4'h8, 4'h8, 1'b1);
        for (int i = 0; i < 400; i++)
            step(NP'($urandom_range(0, 15)), NP'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : 0),
                 $urandom_range(0, 7) != 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/c_arb_grant_hold.md
Name: c_arb_grant_hold

Overview:
- Sits directly downstream of the matrix arbiter and consumes its one-hot grant.
- Converts single-cycle arbitration results into packet-granular grants: it registers the winner and holds (locks) that grant until the winner's tail flit.
- While locked, it suppresses requests to the arbiter and drives the arbiter's priority-update strobe only when a new winner is accepted.
- Used in switch and VC allocators where multi-flit packets must not be interleaved.

Parameters:
- num_ports, 32, number of requesters; also the width of the req/gnt vectors.
- max_hold, 16, maximum consecutive cycles one grant may be held. Used only with C_ARB_GRANT_HOLD_TIMEOUT_EN; legal range 2..2^16.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- active  input  1  clock-gating enable; when 0, all state holds
- req  input  num_ports  raw requests, bit 0 = port 0
- tail  input  num_ports  per-port flag: the current flit of the port is its last
- arb_req  output  num_ports  masked requests driven to the matrix arbiter
- arb_gnt  input  num_ports  one-hot (or zero) grant returned by the arbiter, same cycle
- arb_update  output  1  priority-update strobe to the arbiter
- gnt  output  num_ports  registered one-hot packet grant
- locked  output  1  a grant is currently held
- timeout  output  1  forced release pulse (0 when the feature is compiled out)

Behaviour:
- Reset: state IDLE, gnt_q = 0, locked = 0, hold counter = 0, timeout = 0. arb_req and arb_update are combinational and 0 while in reset.
- State register is updated only when active = 1. With active = 0, arb_update is forced to 0 and all registers hold.
- Outputs: gnt = gnt_q, locked = (state == LOCKED).
- release = locked & |(gnt_q & req & tail), plus force_rel when the timeout feature is compiled in.
- arb_req:
  - IDLE: arb_req = req.
  - LOCKED with release: arb_req = req & ~gnt_q, so a different port may win in the same cycle.
  - LOCKED without release: arb_req = 0.
- accept = |arb_gnt & (IDLE | release). arb_update = accept & active.
- IDLE with accept: next cycle gnt_q = arb_gnt, state LOCKED, counter = 0. Grant latency is 1 cycle from arbitration to gnt.
- IDLE without accept: remain IDLE, gnt_q = 0.
- LOCKED with release and accept: gnt_q = arb_gnt, stay LOCKED, counter = 0 (back-to-back packets, no bubble).
- LOCKED with release and no accept: gnt_q = 0, state IDLE.
- LOCKED without release: gnt_q holds; counter increments and saturates at max_hold-1.
- Winner deasserts req without a tail: the grant is still held (bubble cycle); no release.
- tail on a non-granted port is ignored.
- A non-one-hot arb_gnt is illegal; a simulation-only assertion flags it.
- Reset asserted mid-packet: immediate asynchronous clear to IDLE; gnt drops to 0 without waiting for the tail.

Optional Feature:
- Macro: C_ARB_GRANT_HOLD_TIMEOUT_EN.
- Defined:
  - force_rel = locked & (counter == max_hold-1) & ~(normal release).
  - The forced release behaves exactly like a release, including same-cycle re-arbitration that excludes the current holder.
  - timeout pulses 1 for that cycle.
  - The counter is ceil(log2(max_hold)) bits wide.
- Undefined: no counter is instantiated, timeout is tied to 0, and a grant is held indefinitely until the tail.

Test Plan:
- Reset, then req=0x1 with tail=0 for 3 cycles, then tail=0x1 -> arb_update=1 once in cycle 0; gnt=0x1 and locked=1 from cycle 1; arb_req=0 in cycles 1–3; gnt=0 and locked=0 the cycle after the tail.
- req=0x3, port 0 sends a 2-flit packet then port 1 sends a 1-flit packet -> on port 0's tail cycle arb_req=0x2 and arb_update=1; next cycle gnt=0x2 with no idle cycle between them.
- Port 0 holding, req drops to 0x0 for 2 cycles without tail -> gnt stays 0x1; other requests masked (arb_req=0).
- Single-flit packets on all 4 ports (num_ports=4, req=0xF, tail=0xF continuously) -> gnt rotates one-hot each cycle following the arbiter; arb_update=1 every cycle.
- Reset asserted while locked with gnt=0x4 -> gnt=0, locked=0 immediately (asynchronous); the first arb_update after reset deassertion behaves as from IDLE.
- With C_ARB_GRANT_HOLD_TIMEOUT_EN, max_hold=4, port 2 holds without tail and port 3 requests -> timeout=1 in the 4th locked cycle; gnt=0x8 the next cycle.
  - Without the macro: gnt stays 0x4 and timeout stays 0.
